// File: rtl/argon_pkg.sv
// Shared definitions for the argon front end: sequencer state encodings and
// the branch-type codes used by both BranchManager and pc_sequencer.
package argon_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_t;

  // Branch-type codes (funct3 encoding), single definition for all consumers
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/pc_sequencer.sv
// Program counter owner: offers fetch addresses over valid/ready, redirects on
// taken branches/jumps and squashes IF/ID for FLUSH_CYCLES cycles afterwards.
module pc_sequencer
  import argon_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter int          INSTR_BYTES  = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_branch_valid,
  input  logic              i_take_branch,
  input  logic              i_jump_valid,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_fetch_ready,
  output logic              o_fetch_valid,
  output logic [ADDR_W-1:0] o_fetch_addr,
  output logic              o_flush,
  output logic              o_misalign
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0]      ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0]      PC_STEP    = ADDR_W'(INSTR_BYTES);

  seq_state_t             state, state_nxt;
  logic [ADDR_W-1:0]      pc, pc_nxt;
  logic [FLUSH_CNT_W-1:0] cnt, cnt_nxt;
  logic                   mis_nxt;
  logic                   redirect;

  assign redirect     = i_jump_valid | (i_branch_valid & i_take_branch);
  assign o_fetch_addr = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    mis_nxt   = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN, ST_FLUSH: begin
        if (redirect) begin
          pc_nxt    = i_target;
          state_nxt = ST_FLUSH;
          cnt_nxt   = FLUSH_INIT;
          mis_nxt   = |(i_target & ALIGN_MASK);
        end else begin
          // Stall only freezes the PC; an in-progress flush keeps counting down
          if (!i_stall && state == ST_RUN && o_fetch_valid && i_fetch_ready)
            pc_nxt = pc + PC_STEP;
          if (state == ST_FLUSH) begin
            if (cnt == '0) state_nxt = ST_RUN;
            else           cnt_nxt   = cnt - 1'b1;
          end
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_BOOT;
      pc            <= RESET_VECTOR[ADDR_W-1:0];
      cnt           <= '0;
      o_fetch_valid <= 1'b0;
      o_flush       <= 1'b0;
      o_misalign    <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      cnt           <= cnt_nxt;
      // Outputs are decoded from the next state so they line up with it
      o_fetch_valid <= (state_nxt == ST_RUN);
      o_flush       <= (state_nxt == ST_FLUSH);
      o_misalign    <= mis_nxt;
    end
  end

endmodule
